// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory access stage for a 32-bit pipeline.
// Validates a load/store from EX/MEM, drives a word-aligned bus transaction,
// waits for mem_resp (bounded by MAX_WAIT) and formats the load result.
module mem_access_unit #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_read,
    input  logic        ex_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        err,
    output logic        timeout,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    localparam logic [15:0] MAX_WAIT_C = 16'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] wait_cnt_r;
    logic [2:0]  funct3_r;
    logic [1:0]  offset_r;
    logic        legal_s;
    logic        aligned_s;
    logic        accept_s;
    logic        reject_s;
    logic        wait_last_s;
    logic [3:0]  mask_s;
    logic [31:0] wdata_s;

    // Select the addressed byte/halfword of a bus word and extend it per funct3.
    function automatic logic [31:0] format_load(input logic [2:0] f3,
                                                input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  format_load = {{24{sh[7]}}, sh[7:0]};
            3'b001:  format_load = {{16{sh[15]}}, sh[15:0]};
            3'b100:  format_load = {24'h000000, sh[7:0]};
            3'b101:  format_load = {16'h0000, sh[15:0]};
            default: format_load = sh;
        endcase
    endfunction

    // Decode the EX/MEM request: legality, alignment, byte enables, store data.
    always_comb begin
        legal_s   = 1'b0;
        aligned_s = 1'b0;
        mask_s    = 4'b1111;
        wdata_s   = ex_wdata << {ex_addr[1:0], 3'b000};
        if (ex_read) begin
            case (ex_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_s = 1'b1;
                default:                                legal_s = 1'b0;
            endcase
        end else begin
            case (ex_funct3)
                3'b000, 3'b001, 3'b010: legal_s = 1'b1;
                default:                legal_s = 1'b0;
            endcase
        end
        // funct3[1:0] gives the access size for both signed and unsigned loads
        case (ex_funct3[1:0])
            2'b00:   aligned_s = 1'b1;
            2'b01:   aligned_s = ~ex_addr[0];
            2'b10:   aligned_s = (ex_addr[1:0] == 2'b00);
            default: aligned_s = 1'b0;
        endcase
        if (ex_write) begin
            case (ex_funct3[1:0])
                2'b00:   mask_s = 4'b0001 << ex_addr[1:0];
                2'b01:   mask_s = 4'b0011 << ex_addr[1:0];
                default: mask_s = 4'b1111;
            endcase
        end else begin
            mask_s = 4'b1111;
        end
        accept_s    = (state_r == IDLE) && ex_valid && (ex_read ^ ex_write) && legal_s && aligned_s;
        reject_s    = (state_r == IDLE) && ex_valid && (ex_read || ex_write) && !accept_s;
        wait_last_s = ((wait_cnt_r + 16'd1) == MAX_WAIT_C);
    end

    // Stall while an access is being accepted or is in flight.
    always_comb begin
        stall = accept_s || (state_r == ACCESS);
    end

    // Next-state logic; a response takes priority over a simultaneous timeout.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_next_s = ACCESS;
                else          state_next_s = IDLE;
            end
            ACCESS: begin
                if (mem_resp || wait_last_s) state_next_s = DONE;
                else                         state_next_s = ACCESS;
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_next_s;
    end

    // Registered bus strobes, load result, status pulses and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r      <= 16'd0;
            funct3_r        <= 3'b000;
            offset_r        <= 2'b00;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= 32'h0000_0000;
            mem_wdata       <= 32'h0000_0000;
            mem_byte_enable <= 4'b0000;
            load_data       <= 32'h0000_0000;
            load_valid      <= 1'b0;
            err             <= 1'b0;
            timeout         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    load_valid <= 1'b0;
                    load_data  <= 32'h0000_0000;
                    timeout    <= 1'b0;
                    err        <= reject_s;
                    if (accept_s) begin
                        wait_cnt_r      <= 16'd0;
                        funct3_r        <= ex_funct3;
                        offset_r        <= ex_addr[1:0];
                        mem_read        <= ex_read;
                        mem_write       <= ex_write;
                        mem_address     <= {ex_addr[31:2], 2'b00};
                        mem_wdata       <= wdata_s;
                        mem_byte_enable <= mask_s;
                    end else begin
                        wait_cnt_r <= wait_cnt_r;
                    end
                end
                ACCESS: begin
                    err <= 1'b0;
                    if (mem_resp) begin
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        load_valid <= mem_read;
                        load_data  <= mem_read ? format_load(funct3_r, offset_r, mem_rdata) : 32'h0000_0000;
                    end else if (wait_last_s) begin
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        timeout    <= 1'b1;
                        load_valid <= 1'b0;
                        load_data  <= 32'h0000_0000;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 16'd1;
                    end
                end
                DONE: begin
                    load_valid <= 1'b0;
                    load_data  <= 32'h0000_0000;
                    timeout    <= 1'b0;
                    err        <= 1'b0;
                end
                default: begin
                    mem_read   <= 1'b0;
                    mem_write  <= 1'b0;
                    load_valid <= 1'b0;
                    load_data  <= 32'h0000_0000;
                    timeout    <= 1'b0;
                    err        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit (MAX_WAIT overridden to 4).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_read, ex_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic        stall, load_valid, err, timeout, mem_read, mem_write;
    logic [31:0] load_data, mem_address, mem_wdata, mem_rdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_resp;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_unit #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_read(ex_read), .ex_write(ex_write),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .err(err), .timeout(timeout), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd);
        ex_valid  = 1'b1;
        ex_read   = rd;
        ex_write  = wr;
        ex_funct3 = f3;
        ex_addr   = addr;
        ex_wdata  = wd;
    endtask

    task automatic clear_req();
        ex_valid = 1'b0;
        ex_read  = 1'b0;
        ex_write = 1'b0;
    endtask

    // Accept-cycle stall check, then one load with response in first ACCESS cycle.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [31:0] exp_data);
        drive_req(1'b1, 1'b0, f3, addr, 32'h0);
        #1 check_val({tag, "_stall_accept"}, {31'd0, stall}, 32'd1);
        tick();
        clear_req();
        mem_rdata = rdata;
        mem_resp  = 1'b1;
        #1;
        check_val({tag, "_addr"}, mem_address, exp_addr);
        check_val({tag, "_rd_strobe"}, {31'd0, mem_read}, 32'd1);
        check_val({tag, "_stall_access"}, {31'd0, stall}, 32'd1);
        tick();
        mem_resp = 1'b0;
        check_val({tag, "_data"}, load_data, exp_data);
        check_val({tag, "_valid"}, {31'd0, load_valid}, 32'd1);
        check_val({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
        check_val({tag, "_strobe_done"}, {31'd0, mem_read}, 32'd0);
        tick();
        check_val({tag, "_valid_idle"}, {31'd0, load_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_req();
        ex_funct3 = 3'b000;
        ex_addr   = 32'h0;
        ex_wdata  = 32'h0;
        mem_rdata = 32'h0;
        mem_resp  = 1'b0;
        #12;
        check_val("rst_stall", {31'd0, stall}, 32'd0);
        check_val("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check_val("rst_addr", mem_address, 32'd0);
        check_val("rst_flags", {29'd0, load_valid, err, timeout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // lb 0x103 -> sign-extended 0x80
        do_load("lb", 3'b000, 32'h0000_0103, 32'h80FF_1234, 32'h0000_0100, 32'hFFFF_FF80);
        // lhu 0x006 -> zero-extended upper half
        do_load("lhu", 3'b101, 32'h0000_0006, 32'h8001_0000, 32'h0000_0004, 32'h0000_8001);
        // lh same bytes sign-extended
        do_load("lh", 3'b001, 32'h0000_0006, 32'h8001_0000, 32'h0000_0004, 32'hFFFF_8001);
        // lbu offset 1
        do_load("lbu", 3'b100, 32'h0000_0011, 32'h1234_C678, 32'h0000_0010, 32'h0000_00C6);
        // lw pass-through
        do_load("lw", 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0040, 32'hDEAD_BEEF);

        // sh 0x202: strobe held over two waiting cycles, response on the third
        drive_req(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD);
        #1 check_val("sh_stall_accept", {31'd0, stall}, 32'd1);
        tick();
        clear_req();
        check_val("sh_be", {28'd0, mem_byte_enable}, 32'h0000_000C);
        check_val("sh_wdata", mem_wdata, 32'hABCD_0000);
        check_val("sh_addr", mem_address, 32'h0000_0200);
        tick();
        tick();
        check_val("sh_wr_held", {31'd0, mem_write}, 32'd1);
        check_val("sh_wdata_held", mem_wdata, 32'hABCD_0000);
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        check_val("sh_wr_done", {31'd0, mem_write}, 32'd0);
        check_val("sh_no_load_valid", {31'd0, load_valid}, 32'd0);
        check_val("sh_timeout", {31'd0, timeout}, 32'd0);
        tick();

        // sb at offset 1: single lane, data shifted by 8
        drive_req(1'b0, 1'b1, 3'b000, 32'h0000_0031, 32'h0000_00A5);
        tick();
        clear_req();
        check_val("sb_be", {28'd0, mem_byte_enable}, 32'h0000_0002);
        check_val("sb_wdata", mem_wdata, 32'h0000_A500);
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        tick();

        // Rejected requests: misaligned lw, illegal load funct3, read+write both set
        drive_req(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0);
        #1 check_val("mis_stall", {31'd0, stall}, 32'd0);
        tick();
        clear_req();
        #1;
        check_val("mis_err", {31'd0, err}, 32'd1);
        check_val("mis_no_strobe", {30'd0, mem_read, mem_write}, 32'd0);
        check_val("mis_stall_after", {31'd0, stall}, 32'd0);
        tick();
        check_val("mis_err_pulse", {31'd0, err}, 32'd0);

        drive_req(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0);
        tick();
        clear_req();
        check_val("f3_err", {31'd0, err}, 32'd1);
        check_val("f3_no_strobe", {31'd0, mem_read}, 32'd0);
        tick();

        drive_req(1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0);
        tick();
        clear_req();
        check_val("rw_err", {31'd0, err}, 32'd1);
        check_val("rw_no_strobe", {30'd0, mem_read, mem_write}, 32'd0);
        tick();

        // Timeout: MAX_WAIT = 4, strobe high 4 cycles then abort
        drive_req(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
        mem_rdata = 32'h1111_2222;
        tick();
        clear_req();
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("to_strobe_%0d", i), {31'd0, mem_read}, 32'd1);
            check_val($sformatf("to_stall_%0d", i), {31'd0, stall}, 32'd1);
            tick();
        end
        check_val("to_pulse", {31'd0, timeout}, 32'd1);
        check_val("to_strobe_drop", {31'd0, mem_read}, 32'd0);
        check_val("to_load_valid", {31'd0, load_valid}, 32'd0);
        check_val("to_load_data", load_data, 32'd0);
        check_val("to_stall_done", {31'd0, stall}, 32'd0);
        tick();
        check_val("to_pulse_end", {31'd0, timeout}, 32'd0);

        // Reset in 2nd ACCESS cycle, then stray mem_resp
        drive_req(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
        tick();
        clear_req();
        tick();
        check_val("ra_strobe_before", {31'd0, mem_read}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("ra_stall", {31'd0, stall}, 32'd0);
        check_val("ra_strobe", {30'd0, mem_read, mem_write}, 32'd0);
        check_val("ra_addr", mem_address, 32'd0);
        check_val("ra_be", {28'd0, mem_byte_enable}, 32'd0);
        mem_resp = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check_val("stray_valid", {31'd0, load_valid}, 32'd0);
        check_val("stray_stall", {31'd0, stall}, 32'd0);
        check_val("stray_data", load_data, 32'd0);
        mem_resp = 1'b0;

        // First access after reset is accepted on the next edge
        do_load("post_rst", 3'b010, 32'h0000_0500, 32'h0BAD_F00D, 32'h0000_0500, 32'h0BAD_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255: max ACCESS cycles without mem_resp before abort; legal range 1..65535.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ex_valid  input  1  EX/MEM stage holds a valid instruction.
REQ-005 SHALL have port ex_read  input  1  dmem_read bit from the control word.
REQ-006 SHALL have port ex_write  input  1  dmem_write bit from the control word.
REQ-007 SHALL have port ex_funct3  input  3  load or store funct3.
REQ-008 SHALL have port ex_addr  input  32  byte address from the ALU.
REQ-009 SHALL have port ex_wdata  input  32  rs2 store data.
REQ-010 SHALL have port stall  output  1  freeze the pipeline.
REQ-011 SHALL have port load_data  output  32  formatted load result.
REQ-012 SHALL have port load_valid  output  1  load_data valid, one-cycle pulse.
REQ-013 SHALL have port err  output  1  one-cycle pulse: misaligned, illegal funct3, or read and write both set.
REQ-014 SHALL have port timeout  output  1  one-cycle pulse: access aborted.
REQ-015 SHALL have ports mem_read and mem_write  output  1 each  bus strobes.
REQ-016 SHALL have port mem_address  output  32  word-aligned address, bits [1:0] = 0.
REQ-017 SHALL have ports mem_wdata  output  32  and mem_byte_enable  output  4  (rv32i_mem_wmask).
REQ-018 SHALL have ports mem_rdata  input  32  and mem_resp  input  1.

Function
REQ-019 SHALL implement FSM IDLE, ACCESS, DONE.
REQ-020 IDLE: an access is accepted when ex_valid is set, exactly one of ex_read/ex_write is set, funct3 is legal and the address is aligned; accept registers word address, wdata, mask and funct3, and moves to ACCESS.
REQ-021 Legal funct3: loads 000, 001, 010, 100, 101; stores 000, 001, 010; any other funct3 is illegal.
REQ-022 Alignment: halfword requires addr[0] = 0; word requires addr[1:0] = 00; byte is always aligned.
REQ-023 In IDLE with ex_valid set and ex_read or ex_write set but the access not accepted: err pulses for one cycle, no bus access, stall = 0, state remains IDLE.
REQ-024 Byte enables: sb = 0001 << addr[1:0]; sh = 0011 << addr[1:0]; sw = 1111; all loads = 1111.
REQ-025 Store data: mem_wdata = ex_wdata << (8*addr[1:0]).
REQ-026 stall = 1 combinationally in the IDLE accept cycle and in every ACCESS cycle; stall = 0 in DONE.
REQ-027 ACCESS: mem_read or mem_write, plus mem_address, mem_wdata and mem_byte_enable, are registered and held stable until mem_resp.
REQ-028 mem_resp in ACCESS moves to DONE in the same edge; the load result is captured at that edge; strobes are 0 in DONE.
REQ-029 Load format: select byte/half at addr[1:0]; lb and lh sign-extend; lbu and lhu zero-extend; lw passes the word through.
REQ-030 DONE: load_valid = 1 for a load; ex_* inputs are ignored; next state is IDLE.
REQ-031 A 16-bit wait counter clears on accept and increments each ACCESS cycle; when it reaches MAX_WAIT without mem_resp: strobes drop, timeout pulses, load_data = 0, load_valid = 0, next state DONE.
REQ-032 mem_resp outside ACCESS SHALL be ignored.
REQ-033 Minimum latency: accept edge 0, ACCESS with resp at cycle 1, DONE at cycle 2; stall high exactly 2 cycles.

Reset
REQ-034 rst_n low, asynchronously and at any state including mid-ACCESS, SHALL force IDLE, counter 0, and all outputs 0 (stall, load_data, load_valid, err, timeout, mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable).
REQ-035 After rst_n rises, the first accept SHALL be possible on the next clock edge.

Verification
REQ-036 lb addr 0x103, mem_rdata 0x80FF_1234, resp in 1st ACCESS cycle -> mem_address 0x100, load_data 0xFFFF_FF80, stall high 2 cycles.
REQ-037 sh addr 0x202, wdata 0x0000_ABCD -> mem_byte_enable 1100, mem_wdata 0xABCD_0000, mem_write held until resp.
REQ-038 lw addr 0x101 -> err pulse, no strobe, stall 0; funct3 011 load -> err pulse.
REQ-039 MAX_WAIT 4, no resp -> strobe high 4 cycles, then timeout pulse, load_valid 0, IDLE.
REQ-040 rst_n low in 2nd ACCESS cycle -> all outputs 0 immediately; stray mem_resp afterward ignored.
REQ-041 lhu addr 0x006, rdata 0x8001_0000 -> load_data 0x0000_8001.
